// File: rtl/apb_reg_bridge_if.sv
// rtl/apb_reg_bridge_if.sv - APB3 slave side and register-bus master side of the bridge
interface apb_reg_bridge_if #(
    parameter int REG_AW = 8,
    parameter int REG_DW = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [REG_AW-1:0] paddr;
    logic [REG_DW-1:0] pwdata;
    logic [REG_DW-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic              reg_req;
    logic              reg_wr;
    logic [REG_AW-1:0] reg_addr;
    logic [REG_DW-1:0] reg_wdata;
    logic [REG_DW-1:0] reg_rdata;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, reg_rdata,
        output prdata, pready, pslverr, reg_req, reg_wr, reg_addr, reg_wdata
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, reg_rdata,
        input  prdata, pready, pslverr, reg_req, reg_wr, reg_addr, reg_wdata
    );
endinterface

// File: rtl/apb_reg_bridge.sv
// rtl/apb_reg_bridge.sv - APB3 slave to single-cycle register-bus request bridge
module apb_reg_bridge #(
    parameter int REG_AW   = 8,
    parameter int REG_DW   = 8,
    parameter int RD_LAT   = 1,
    parameter int ADDR_MAX = 2**REG_AW-1
) (
    input logic              clk,
    input logic              rst,
    apb_reg_bridge_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [REG_AW:0] ADDR_LIM = (REG_AW+1)'(ADDR_MAX);
    localparam logic [2:0]      LAT      = 3'(RD_LAT);

    state_t            state;
    state_t            state_next;
    logic              wr_q;
    logic              err_q;
    logic [REG_AW-1:0] addr_q;
    logic [REG_DW-1:0] wdata_q;
    logic [REG_DW-1:0] prdata_q;
    logic [2:0]        cnt;
    logic              setup;

    assign setup = bus.psel && !bus.penable;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (setup) state_next = REQ;
            REQ:     state_next = (wr_q || err_q) ? RESP : WAIT;
            WAIT:    if (cnt == 3'd1) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Holding registers double as the register-bus address/data outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            prdata_q <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        wr_q    <= bus.pwrite;
                        addr_q  <= bus.paddr;
                        wdata_q <= bus.pwdata;
                        err_q   <= ({1'b0, bus.paddr} > ADDR_LIM);
                    end
                end
                REQ: begin
                    if (!wr_q && !err_q) cnt <= LAT;
                    else if (!wr_q)      prdata_q <= '0;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) prdata_q <= bus.reg_rdata;
                end
                default: ;
            endcase
        end
    end

    assign bus.reg_req   = (state == REQ) && !err_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.pready    = (state == RESP);
    assign bus.pslverr   = (state == RESP) && err_q;
    assign bus.prdata    = prdata_q;
endmodule

// File: doc/apb_reg_bridge.md
# apb_reg_bridge

APB3 slave to simple register-bus master bridge. Converts each APB transfer from the system interconnect into a single-cycle `reg_req` pulse on the register bus that feeds the block register files. It waits a fixed read latency for `reg_rdata` and completes the APB transfer with `pready`, flagging out-of-range addresses with `pslverr`.

## Interface
- `REG_AW`, 8: register address width; also the `paddr` width.
- `REG_DW`, 8: register data width; also the `pwdata` and `prdata` width.
- `RD_LAT`, 1: number of cycles from the `reg_req` cycle until `reg_rdata` is valid. Legal range 1..4.
- `ADDR_MAX`, 2**REG_AW-1: highest legal register address.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `psel`  in  1  APB select.
- `penable`  in  1  APB enable.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  REG_AW  APB address.
- `pwdata`  in  REG_DW  APB write data.
- `prdata`  out  REG_DW  APB read data.
- `pready`  out  1  transfer complete.
- `pslverr`  out  1  error response; valid only while `pready` = 1.
- `reg_req`  out  1  1 = valid register access request, one cycle per transfer.
- `reg_wr`  out  1  1 = write, 0 = read.
- `reg_addr`  out  REG_AW  register address.
- `reg_wdata`  out  REG_DW  register write data.
- `reg_rdata`  in  REG_DW  register read data.

## Operation
- FSM states are IDLE, REQ, WAIT and RESP; the state is held in a register.
- **IDLE:**
  - On `psel`=1 and `penable`=0 (setup phase), capture `pwrite`, `paddr` and `pwdata` into holding registers.
  - Compute `err` = (`paddr` > `ADDR_MAX`).
  - Go to REQ.
- **REQ:**
  - `reg_req` = !`err`. `reg_wr`, `reg_addr` and `reg_wdata` come from the holding registers.
  - If the transfer is a write or `err` = 1, go to RESP.
  - If the transfer is a read, load the latency counter with `RD_LAT` and go to WAIT.
- **WAIT:**
  - The counter decrements each cycle.
  - In the cycle the counter equals 1, register `reg_rdata` into `prdata` and go to RESP.
- **RESP:**
  - `pready` = 1 for exactly one cycle and `pslverr` = `err`. Go to IDLE.
  - On an error read, `prdata` is loaded with 0 (at the REQ→RESP edge).
- `prdata` changes only on read completion; writes leave it unchanged.
- `reg_addr`, `reg_wr` and `reg_wdata` hold their last values outside REQ. Only `reg_req` qualifies them.
- Out-of-range accesses never assert `reg_req`. This also applies to writes.
- If `psel` deasserts mid-transfer (protocol violation), the bridge still completes through RESP. Inputs are not re-sampled until IDLE.
- A setup phase seen in any state other than IDLE is ignored. APB guarantees the next setup comes no earlier than the cycle after `pready`.
- Reset value of every output is 0: `prdata`, `pready`, `pslverr`, `reg_req`, `reg_wr`, `reg_addr`, `reg_wdata`. State resets to IDLE and the counter to 0.
- Reset mid-transfer:
  - FSM returns to IDLE on the next edge.
  - `reg_req` and `pready` are 0 from that cycle.
  - No completion is issued for the aborted transfer.

## Timing
- Setup phase is cycle C0.
- `reg_req` is high in C1, the first access cycle (`penable`=1).
- Write: `pready` is high in C2. Total 2 APB access cycles at 1 wait state.
- Read: `reg_rdata` is sampled at the end of cycle C1+`RD_LAT`. `pready` and `prdata` are valid in C(2+`RD_LAT`). For `RD_LAT`=1, `pready` is in C3.
- Error: `pready`=1 and `pslverr`=1 in C2, for both read and write.
- Back-to-back transfers:
  - Next setup phase is earliest at RESP+1.
  - Minimum spacing between `reg_req` pulses is 3 cycles for writes and 3+`RD_LAT` cycles for reads.
- `pready` and `pslverr` are decoded directly from the state/err registers, with no input-to-output combinational path.
- All outputs are glitch-free.

## Test plan
1. **Reset values.** Hold `rst`=1 for 3 cycles with random APB inputs → all outputs 0, no `reg_req`.
2. **Write.** Write `paddr`=0x12, `pwdata`=0xA5 → `reg_req`=1, `reg_wr`=1, `reg_addr`=0x12, `reg_wdata`=0xA5 in C1 only. `pready`=1 and `pslverr`=0 in C2.
3. **Read.** `RD_LAT`=1 and `RD_LAT`=3. Read `paddr`=0x34 with the model returning 0x5C exactly `RD_LAT` cycles after `reg_req` → `prdata`=0x5C with `pready` in C3 for `RD_LAT`=1 and in C5 for `RD_LAT`=3. Exactly one `reg_req` per transfer.
4. **Out of range.** `ADDR_MAX`=0x3F; write and read to 0x40 → no `reg_req`. `pready`=1 and `pslverr`=1 in C2. `prdata`=0 for the read.
5. **Back-to-back.** Write 0x01→0x11, then read 0x01, with setup immediately after `pready` → `reg_req` pulses spaced 3 cycles apart. Read returns 0x11 and prior `prdata` is preserved through the write.
6. **Reset mid-read.** `RD_LAT`=3; assert `rst` during WAIT → IDLE next cycle with no `pready`. A subsequent read of 0x02 completes normally.
